mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline latch.
- Takes the latched WB/M control, ALU result, store data, PC and zero flag, and resolves the branch decision.
- Drives a req/ack data-memory interface for loads and stores.
- Stalls the pipeline while an access is outstanding, then loads the MEM/WB pipeline register.

Parameters:
- MAX_WAIT, 16: ACCESS cycles without mem_ack before timeout (≥1).
- AW, 32: data-memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- WB  in  2  {RegWrite, MemtoReg} from EX/MEM
- M  in  3  {Branch, MemRead, MemWrite} from EX/MEM
- PC  in  32  branch target from EX/MEM
- zero  in  1  ALU zero flag
- ALUresult  in  32  ALU result / memory address
- writeData  in  32  store data
- writeRegister  in  5  destination register
- mem_req  out  1  access request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  AW  captured address
- mem_wdata  out  32  captured store data
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  32  load data, valid with mem_ack
- stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- PCSrc  out  1  take branch
- branch_target  out  32  equals PC input
- mem_err  out  1  one-cycle pulse on timeout
- WB_output  out  2  MEM/WB control
- readData_output  out  32  MEM/WB load data
- ALUresult_output  out  32  MEM/WB ALU result
- writeRegister_output  out  5  MEM/WB destination

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all registered outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_err and all MEM/WB outputs; wait counter 0. Asserting reset mid-access drops mem_req immediately and abandons the access.
- States: IDLE, ACCESS.
- access = M[1] | M[0]. If both bits are set, the access is a store (MemWrite wins).
- IDLE, access=0:
  - stall=0.
  - At the clock edge, MEM/WB registers take WB, ALUresult and writeRegister; readData_output is loaded with 0.
  - Latency 1 cycle.
- IDLE, access=1:
  - stall=1 (combinational).
  - At the edge, mem_req←1, mem_we←M[0], mem_addr←ALUresult[AW-1:0], mem_wdata←writeData; state←ACCESS; counter←0.
  - MEM/WB takes a bubble (WB_output←0).
- ACCESS, mem_ack=0:
  - stall=1; counter increments.
  - MEM/WB takes a bubble.
- ACCESS, mem_ack=1:
  - stall=0 in the same cycle (combinational), so upstream advances at this edge.
  - At the edge, mem_req←0, state←IDLE.
  - MEM/WB takes WB, ALUresult and writeRegister; readData_output←mem_rdata for a load, 0 for a store.
  - Minimum load/store latency is 2 cycles.
- ACCESS, counter==MAX_WAIT-1 and no ack (timeout):
  - Treated as completion with stall=0.
  - mem_err pulses for one cycle; readData_output←0; WB_output←{0, WB[0]}, i.e. RegWrite is squashed.
  - state←IDLE.
- Ack arriving on the timeout cycle: the ack wins and mem_err is not raised.
- mem_ack outside ACCESS is ignored.
- PCSrc = M[2] & zero & ~stall (combinational); branch_target = PC.
- Inputs are guaranteed stable while stall=1, because upstream holds.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an access with ALUresult[1:0]≠0 issues no request and stall stays 0.
  - mem_err pulses for one cycle.
  - MEM/WB loads with RegWrite squashed and readData_output=0.
- Undefined: no alignment check; mem_addr is passed through unmodified.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, ACCESS};
  - control-bit index constants: RegWrite=1, MemtoReg=0 in WB; Branch=2, MemRead=1, MemWrite=0 in M;
  - the MEM/WB bubble constant 2'b00.
- Sub-module mem_wb_reg: the MEM/WB pipeline register with load/bubble select.
- FSM, counter and memory interface stay in the top level.

Test Plan:
- Reset assertion → every output reads 0 and state is IDLE. Reset asserted during ACCESS → mem_req falls without waiting for a clock edge.
- ALU op: WB=2'b10, M=0, ALUresult=5, writeRegister=3 → no mem_req and stall=0; next edge gives WB_output=2'b10, ALUresult_output=5, writeRegister_output=3.
- Load at address 0x40, memory acks after 2 ACCESS cycles with rdata 0xDEADBEEF:
  - stall high for 3 cycles; mem_addr=0x40, mem_we=0;
  - readData_output=0xDEADBEEF, WB_output=2'b11 after the ack edge;
  - bubbles (WB_output=0) on the preceding edges.
- Store: writeData=0x1F at address 0x8, ack in the first ACCESS cycle → mem_we=1, mem_wdata=0x1F; stall lasts 1 cycle (IDLE issue cycle only); readData_output=0.
- Branch: M=3'b100 with zero=1 → PCSrc=1, branch_target=PC. Same with zero=0 → PCSrc=0.
- Timeout with MAX_WAIT=4 and no ack → mem_err pulses on the 4th ACCESS cycle; WB_output RegWrite=0; state returns to IDLE.
  - With MEM_ALIGN_CHECK_EN defined, a load at address 0x41 → no mem_req, mem_err pulse, no stall.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module   : mem_stage_pkg
// Function : Shared types and control-bit indices for the MEM pipeline stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Bit positions inside the WB and M control bundles
  localparam int unsigned c_WB_REG_WRITE  = 1;
  localparam int unsigned c_WB_MEM_TO_REG = 0;
  localparam int unsigned c_M_BRANCH      = 2;
  localparam int unsigned c_M_MEM_READ    = 1;
  localparam int unsigned c_M_MEM_WRITE   = 0;

  localparam logic [1:0] c_WB_BUBBLE = 2'b00;

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// ============================================================================
// Module   : mem_wb_reg
// Function : MEM/WB pipeline register; loads a result or inserts a bubble.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [1:0]  i_wb,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_read_data,
  input  logic [4:0]  i_write_reg,
  output logic [1:0]  o_wb,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_read_data,
  output logic [4:0]  o_write_reg
);

  logic [1:0]  r_wb;
  logic [31:0] r_alu_result;
  logic [31:0] r_read_data;
  logic [4:0]  r_write_reg;

  // A bubble only clears the control bits; data fields are don't-care downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb         <= c_WB_BUBBLE;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_write_reg  <= '0;
    end else if (i_load) begin
      r_wb         <= i_wb;
      r_alu_result <= i_alu_result;
      r_read_data  <= i_read_data;
      r_write_reg  <= i_write_reg;
    end else begin
      r_wb         <= c_WB_BUBBLE;
    end
  end

  assign o_wb         = r_wb;
  assign o_alu_result = r_alu_result;
  assign o_read_data  = r_read_data;
  assign o_write_reg  = r_write_reg;

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Function : EX/MEM consumer: branch resolve, req/ack data-memory access with
//            timeout, pipeline stall and MEM/WB load. Optional misaligned
//            access trap enabled by MEM_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    WB,
  input  logic [2:0]    M,
  input  logic [31:0]   PC,
  input  logic          zero,
  input  logic [31:0]   ALUresult,
  input  logic [31:0]   writeData,
  input  logic [4:0]    writeRegister,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          stall,
  output logic          PCSrc,
  output logic [31:0]   branch_target,
  output logic          mem_err,
  output logic [1:0]    WB_output,
  output logic [31:0]   readData_output,
  output logic [31:0]   ALUresult_output,
  output logic [4:0]    writeRegister_output
);

  localparam int unsigned    c_CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                r_req, w_req_nxt;
  logic                r_we, w_we_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic [31:0]         r_wdata, w_wdata_nxt;
  logic                r_err, w_err_nxt;
  logic                w_stall;
  logic                w_access;
  logic                w_misaligned;
  logic                w_wb_load;
  logic [1:0]          w_wb_val;
  logic [31:0]         w_rdata_val;

  assign w_access = M[c_M_MEM_READ] | M[c_M_MEM_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (ALUresult[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = 1'b0;
    w_stall     = 1'b0;
    w_wb_load   = 1'b0;
    w_wb_val    = WB;
    w_rdata_val = '0;
    case (r_state)
      IDLE: begin
        if (w_access && !w_misaligned) begin
          w_stall     = 1'b1;
          w_req_nxt   = 1'b1;
          w_we_nxt    = M[c_M_MEM_WRITE];
          w_addr_nxt  = ALUresult[AW-1:0];
          w_wdata_nxt = writeData;
          w_cnt_nxt   = '0;
          w_state_nxt = ACCESS;
        end else if (w_access) begin
          w_err_nxt = 1'b1;
          w_wb_load = 1'b1;
          w_wb_val  = {1'b0, WB[c_WB_MEM_TO_REG]};
        end else begin
          w_wb_load = 1'b1;
        end
      end
      ACCESS: begin
        // Ack takes priority over timeout when both land in the same cycle
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
          w_wb_load   = 1'b1;
          w_rdata_val = r_we ? 32'd0 : mem_rdata;
        end else if (r_cnt == c_CNT_LAST) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
          w_wb_load   = 1'b1;
          w_wb_val    = {1'b0, WB[c_WB_MEM_TO_REG]};
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_wb_load),
    .i_wb         (w_wb_val),
    .i_alu_result (ALUresult),
    .i_read_data  (w_rdata_val),
    .i_write_reg  (writeRegister),
    .o_wb         (WB_output),
    .o_alu_result (ALUresult_output),
    .o_read_data  (readData_output),
    .o_write_reg  (writeRegister_output)
  );

  assign mem_req       = r_req;
  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_err       = r_err;
  assign stall         = w_stall;
  assign PCSrc         = M[c_M_BRANCH] & zero & ~w_stall;
  assign branch_target = PC;

endmodule

`default_nettype wire
